// File: rtl/match_event_counter.sv
// Post-processor for the four-in-a-row sequence detector: counts match events in
// saturating BCD, times the current match, and flags the run type and bad codes.
module match_event_counter #(
    parameter int         DIGITS  = 2,
    parameter int         DWELL_W = 8,
    parameter logic [3:0] Y_ZEROS = 4'b0100,
    parameter logic [3:0] Y_ONES  = 4'b1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  z,
    input  logic [3:0]            y,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [DWELL_W-1:0]    dwell,
    output logic                  kind,
    output logic                  sat,
    output logic                  err
);

    localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};

    logic                z_prev;
    logic                tracking;
    logic                rise;
    logic                all_nines;
    logic                bad_code;
    logic [4*DIGITS-1:0] count_next;

    assign rise     = z & ~z_prev;
    assign bad_code = (y != Y_ZEROS) && (y != Y_ONES);

    // Ripple BCD increment: a digit only advances when every lower digit wraps.
    always_comb begin
        logic carry;
        logic [3:0] digit;
        count_next = count_bcd;
        all_nines  = 1'b1;
        carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count_bcd[4*i +: 4];
            if (digit != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (digit == 4'd9) begin
                    count_next[4*i +: 4] = 4'd0;
                end else begin
                    count_next[4*i +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // tracking marks a match that was actually counted; a match already in
    // progress when clear drops is not timed until its next rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            z_prev    <= 1'b0;
            tracking  <= 1'b0;
            count_bcd <= '0;
            dwell     <= '0;
            kind      <= 1'b0;
            sat       <= 1'b0;
            err       <= 1'b0;
        end else begin
            z_prev <= z;
            if (clear) begin
                tracking  <= 1'b0;
                count_bcd <= '0;
                dwell     <= '0;
                kind      <= 1'b0;
                sat       <= 1'b0;
                err       <= 1'b0;
            end else begin
                if (rise) begin
                    if (all_nines) begin
                        sat <= 1'b1;
                    end else begin
                        count_bcd <= count_next;
                    end
                    kind     <= (y == Y_ONES);
                    dwell    <= {{(DWELL_W-1){1'b0}}, 1'b1};
                    tracking <= 1'b1;
                end else if (z && tracking && (dwell != DWELL_MAX)) begin
                    dwell <= dwell + 1'b1;
                end
                if (z && bad_code) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_match_event_counter.sv
// Directed and random checks of match_event_counter against an integer-count
// reference model converted to BCD only at comparison time.
module tb_match_event_counter;

    localparam int DIGITS  = 2;
    localparam int DWELL_W = 8;
    localparam int CNT_MAX = 99;
    localparam int DW_MAX  = 255;

    logic                  clock;
    logic                  reset;
    logic                  clear;
    logic                  z;
    logic [3:0]            y;
    logic [4*DIGITS-1:0]   count_bcd;
    logic [DWELL_W-1:0]    dwell;
    logic                  kind;
    logic                  sat;
    logic                  err;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    int m_count;
    int m_dwell;
    bit m_kind;
    bit m_sat;
    bit m_err;
    bit m_zprev;
    bit m_live;

    match_event_counter #(
        .DIGITS (DIGITS),
        .DWELL_W(DWELL_W),
        .Y_ZEROS(4'b0100),
        .Y_ONES (4'b1000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .z        (z),
        .y        (y),
        .count_bcd(count_bcd),
        .dwell    (dwell),
        .kind     (kind),
        .sat      (sat),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
        logic [4*DIGITS-1:0] v;
        int k;
        v = '0;
        k = n;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(k % 10);
            k = k / 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_count = 0; m_dwell = 0; m_kind = 0; m_sat = 0; m_err = 0;
        m_zprev = 0; m_live = 0;
    endtask

    task automatic model_step();
        bit rise;
        rise = z && !m_zprev;
        if (clear) begin
            m_count = 0; m_dwell = 0; m_kind = 0; m_sat = 0; m_err = 0; m_live = 0;
        end else begin
            if (rise) begin
                if (m_count == CNT_MAX) m_sat = 1;
                else m_count++;
                m_kind  = (y == 4'b1000);
                m_dwell = 1;
                m_live  = 1;
            end else if (z && m_live && m_dwell < DW_MAX) begin
                m_dwell++;
            end
            if (z && y != 4'b0100 && y != 4'b1000) m_err = 1;
        end
        m_zprev = z;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [3:0] yy);
        z = 1'b1; y = yy; tick();
        z = 1'b0; tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(count_bcd), 32'(to_bcd(m_count)));
        chk({tag, ".dwell"}, 32'(dwell), 32'(m_dwell));
        chk({tag, ".kind"},  32'(kind), 32'(m_kind));
        chk({tag, ".sat"},   32'(sat), 32'(m_sat));
        chk({tag, ".err"},   32'(err), 32'(m_err));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; z = 1'b0; y = 4'b0000;
        model_reset();
        #1;
        check_model("reset_async");
        ticks(2);
        check_model("reset_held");
        reset = 1'b0;

        // first zeros-run event lasting 5 cycles
        ticks(3);
        z = 1'b1; y = 4'b0100; ticks(5);
        z = 1'b0; tick();
        chk("first.count", 32'(count_bcd), 32'h01);
        chk("first.dwell", 32'(dwell), 32'd5);
        chk("first.kind", 32'(kind), 32'd0);
        check_model("first");

        // ten ones pulses, BCD carry into tens digit
        clear = 1'b1; tick(); clear = 1'b0;
        check_model("clear1");
        for (int i = 0; i < 10; i++) pulse(4'b1000);
        chk("carry.count", 32'(count_bcd), 32'h10);
        chk("carry.kind", 32'(kind), 32'd1);
        chk("carry.dwell", 32'(dwell), 32'd1);

        // saturation
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 99; i++) pulse(4'b0100);
        chk("sat99.count", 32'(count_bcd), 32'h99);
        chk("sat99.sat", 32'(sat), 32'd0);
        pulse(4'b1000);
        chk("sat100.count", 32'(count_bcd), 32'h99);
        chk("sat100.sat", 32'(sat), 32'd1);
        check_model("sat100");
        clear = 1'b1; tick(); clear = 1'b0;
        chk("satclr.count", 32'(count_bcd), 32'h00);
        chk("satclr.sat", 32'(sat), 32'd0);

        // dwell saturation
        z = 1'b1; y = 4'b1000; ticks(300);
        z = 1'b0; tick();
        chk("dwellsat.dwell", 32'(dwell), 32'd255);
        chk("dwellsat.count", 32'(count_bcd), 32'h01);
        check_model("dwellsat");

        // clear colliding with a rise
        z = 1'b1; y = 4'b0100; clear = 1'b1; tick();
        clear = 1'b0; ticks(4);
        z = 1'b0; tick();
        chk("collide.count", 32'(count_bcd), 32'h00);
        chk("collide.dwell", 32'(dwell), 32'd0);
        check_model("collide");
        pulse(4'b0100);
        chk("collide_next.count", 32'(count_bcd), 32'h01);

        // bad code with rise, then async reset mid-match
        z = 1'b1; y = 4'b0011; tick();
        chk("err.err", 32'(err), 32'd1);
        chk("err.count", 32'(count_bcd), 32'h02);
        check_model("err");
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_model("midreset");
        @(negedge clock);
        reset = 1'b0;
        #4;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            z = ($urandom_range(0, 99) < 55);
            r = $urandom_range(0, 9);
            y = (r < 4) ? 4'b0100 : (r < 8) ? 4'b1000 : 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 49) == 0);
            tick();
            check_model("rand");
        end
        clear = 1'b0; z = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
